// File: rtl/register_file_stack.sv
// Register file with registered dual read ports, move/swap, ALU result/flag capture and a LIFO stack.
// Latency: reads return pre-edge register contents one cycle later with a one-cycle rd_valid pulse.
// Backpressure: none; a push on a full stack or a pop on an empty stack is dropped and pulses err.
module register_file_stack #(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 8,
    parameter int FLAG_W      = 3,
    parameter int STACK_DEPTH = 8,
    localparam int AW         = $clog2(NUM_REGS),
    localparam int SW         = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     rb,
    input  logic [DATA_W-1:0] wdata,
    input  logic              alu_we,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rd_valid,
    output logic [SW-1:0]     stk_count,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              err
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ1 = 3'd2;
    localparam logic [2:0] OP_READ2 = 3'd3;
    localparam logic [2:0] OP_MOVE  = 3'd4;
    localparam logic [2:0] OP_SWAP  = 3'd5;
    localparam logic [2:0] OP_PUSH  = 3'd6;
    localparam logic [2:0] OP_POP   = 3'd7;

    logic [DATA_W-1:0] regs_q  [NUM_REGS];
    logic [DATA_W-1:0] regs_d  [NUM_REGS];
    logic [DATA_W-1:0] stack_q [STACK_DEPTH];
    logic [DATA_W-1:0] stack_d [STACK_DEPTH];
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic [SW-2:0]     push_idx;
    logic [SW-2:0]     pop_idx;

    // Push writes the slot just above the top; pop reads the top entry.
    assign push_idx = cnt_q[SW-2:0];
    assign pop_idx  = cnt_q[SW-2:0] - (SW-1)'(1);

    assign stk_full  = (cnt_q == SW'(STACK_DEPTH));
    assign stk_empty = (cnt_q == '0);
    assign stk_count = cnt_q;
    assign rdata1    = rdata1_q;
    assign rdata2    = rdata2_q;
    assign rd_valid  = rd_valid_q;
    assign err       = err_q;

    // Next-state: ALU capture first, then op writes so they win per target register.
    always_comb begin
        regs_d     = regs_q;
        stack_d    = stack_q;
        cnt_d      = cnt_q;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;

        if (alu_we) begin
            regs_d[NUM_REGS-1] = alu_result;
            regs_d[NUM_REGS-2] = DATA_W'(alu_flags);
        end

        case (op)
            OP_NOP: ;
            OP_WRITE: regs_d[ra] = wdata;
            OP_READ1: begin
                rdata1_d   = regs_q[ra];
                rd_valid_d = 1'b1;
            end
            OP_READ2: begin
                rdata1_d   = regs_q[ra];
                rdata2_d   = regs_q[rb];
                rd_valid_d = 1'b1;
            end
            // Same-index move/swap is a true no-op, so it must not mask ALU capture.
            OP_MOVE: begin
                if (ra != rb) regs_d[ra] = regs_q[rb];
            end
            OP_SWAP: begin
                if (ra != rb) begin
                    regs_d[ra] = regs_q[rb];
                    regs_d[rb] = regs_q[ra];
                end
            end
            OP_PUSH: begin
                if (stk_full) begin
                    err_d = 1'b1;
                end else begin
                    stack_d[push_idx] = regs_q[ra];
                    cnt_d             = cnt_q + SW'(1);
                end
            end
            OP_POP: begin
                if (stk_empty) begin
                    err_d = 1'b1;
                end else begin
                    regs_d[ra] = stack_q[pop_idx];
                    cnt_d      = cnt_q - SW'(1);
                end
            end
            default: ;
        endcase
    end

    // State registers; reset clears every register, stack slot and output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
            cnt_q      <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            stack_q    <= stack_d;
            cnt_q      <= cnt_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_register_file_stack.sv
// Directed bench for register_file_stack with a queue-based reference model.
// Every negedge the outputs are compared against the model; literal checks pin key values.
// Inputs are driven on negedge; the model advances on each posedge an op is applied.
module tb_register_file_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] op = '0;
    logic [2:0] ra = '0;
    logic [2:0] rb = '0;
    logic [7:0] wdata = '0;
    logic       alu_we = 1'b0;
    logic [7:0] alu_result = '0;
    logic [2:0] alu_flags = '0;
    logic [7:0] rdata1, rdata2;
    logic       rd_valid, stk_full, stk_empty, err;
    logic [3:0] stk_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic [7:0] m_regs [8];
    logic [7:0] m_stk [$];
    logic [7:0] m_r1, m_r2;
    logic       m_vld, m_err;

    register_file_stack dut (
        .clk(clk), .rst(rst), .op(op), .ra(ra), .rb(rb), .wdata(wdata),
        .alu_we(alu_we), .alu_result(alu_result), .alu_flags(alu_flags),
        .rdata1(rdata1), .rdata2(rdata2), .rd_valid(rd_valid),
        .stk_count(stk_count), .stk_full(stk_full), .stk_empty(stk_empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_stk.delete();
        m_r1 = 8'h00; m_r2 = 8'h00; m_vld = 1'b0; m_err = 1'b0;
    endtask

    // Apply one op for one clock and advance the model from the rules.
    task automatic stepx(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                         input logic [7:0] wd, input logic we, input logic [7:0] res,
                         input logic [2:0] fl);
        logic [7:0] nr [8];
        @(negedge clk);
        op = o; ra = a; rb = b; wdata = wd; alu_we = we; alu_result = res; alu_flags = fl;
        @(posedge clk);
        nr = m_regs;
        m_vld = 1'b0;
        m_err = 1'b0;
        if (we) begin
            nr[7] = res;
            nr[6] = {5'b0, fl};
        end
        case (o)
            3'd1: nr[a] = wd;
            3'd2: begin m_r1 = m_regs[a]; m_vld = 1'b1; end
            3'd3: begin m_r1 = m_regs[a]; m_r2 = m_regs[b]; m_vld = 1'b1; end
            3'd4: if (a != b) nr[a] = m_regs[b];
            3'd5: if (a != b) begin nr[a] = m_regs[b]; nr[b] = m_regs[a]; end
            3'd6: if (m_stk.size() < 8) m_stk.push_back(m_regs[a]); else m_err = 1'b1;
            3'd7: if (m_stk.size() > 0) nr[a] = m_stk.pop_back(); else m_err = 1'b1;
            default: ;
        endcase
        m_regs = nr;
    endtask

    task automatic step(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                        input logic [7:0] wd);
        stepx(o, a, b, wd, 1'b0, 8'h00, 3'b000);
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata1", {24'b0, rdata1}, {24'b0, m_r1});
            chk("rdata2", {24'b0, rdata2}, {24'b0, m_r2});
            chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_vld});
            chk("err", {31'b0, err}, {31'b0, m_err});
            chk("stk_count", {28'b0, stk_count}, m_stk.size());
            chk("stk_full", {31'b0, stk_full}, {31'b0, (m_stk.size() == 8)});
            chk("stk_empty", {31'b0, stk_empty}, {31'b0, (m_stk.size() == 0)});
        end
    end

    localparam logic [2:0] NOP = 0, WR = 1, RD1 = 2, RD2 = 3, MOV = 4, SWP = 5, PSH = 6, POPO = 7;

    initial begin
        logic [2:0] order [8];
        logic [7:0] expv;
        model_reset();
        #12;
        chk("reset_rdata1", {24'b0, rdata1}, 32'h0);
        chk("reset_count", {28'b0, stk_count}, 32'h0);
        chk("reset_empty", {31'b0, stk_empty}, 32'h1);
        chk("reset_full", {31'b0, stk_full}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // write / read2 / one-cycle valid
        step(WR, 2, 0, 8'hA5);
        step(WR, 3, 0, 8'h3C);
        step(RD2, 2, 3, 8'h00);
        #1;
        chk("read2_r1", {24'b0, rdata1}, 32'hA5);
        chk("read2_r2", {24'b0, rdata2}, 32'h3C);
        chk("read2_vld", {31'b0, rd_valid}, 32'h1);
        step(NOP, 0, 0, 8'h00);
        #1;
        chk("vld_drop", {31'b0, rd_valid}, 32'h0);

        // swap, move, read1 keeps rdata2
        step(SWP, 2, 3, 8'h00);
        step(RD2, 2, 3, 8'h00);
        #1;
        chk("swap_r1", {24'b0, rdata1}, 32'h3C);
        chk("swap_r2", {24'b0, rdata2}, 32'hA5);
        step(MOV, 0, 2, 8'h00);
        step(RD1, 0, 0, 8'h00);
        #1;
        chk("move_r1", {24'b0, rdata1}, 32'h3C);
        chk("read1_hold_r2", {24'b0, rdata2}, 32'hA5);
        step(SWP, 4, 4, 8'h00);
        step(MOV, 5, 5, 8'h00);

        // ALU capture vs op write priority
        stepx(WR, 7, 0, 8'h11, 1'b1, 8'h7F, 3'b101);
        step(RD2, 6, 7, 8'h00);
        #1;
        chk("alu_flags_r6", {24'b0, rdata1}, 32'h05);
        chk("op_wins_r7", {24'b0, rdata2}, 32'h11);
        stepx(WR, 6, 0, 8'hEE, 1'b1, 8'h77, 3'b010);
        step(RD2, 6, 7, 8'h00);
        #1;
        chk("op_wins_r6", {24'b0, rdata1}, 32'hEE);
        chk("alu_r7", {24'b0, rdata2}, 32'h77);
        stepx(SWP, 6, 6, 8'h00, 1'b1, 8'h5A, 3'b111);
        step(RD2, 6, 7, 8'h00);
        #1;
        chk("noop_swap_alu_r6", {24'b0, rdata1}, 32'h07);
        chk("noop_swap_alu_r7", {24'b0, rdata2}, 32'h5A);

        // fill the stack: R1..R7 then R0, values 0x20+3*i
        for (int i = 0; i < 8; i++) step(WR, 3'(i), 0, 8'(8'h20 + 3 * i));
        for (int i = 0; i < 8; i++) order[i] = 3'((i + 1) % 8);
        for (int i = 0; i < 8; i++) step(PSH, order[i], 0, 8'h00);
        #1;
        chk("full_flag", {31'b0, stk_full}, 32'h1);
        chk("full_count", {28'b0, stk_count}, 32'h8);
        step(PSH, 3, 0, 8'h00);
        #1;
        chk("push_full_err", {31'b0, err}, 32'h1);
        chk("push_full_count", {28'b0, stk_count}, 32'h8);
        step(NOP, 0, 0, 8'h00);
        #1;
        chk("err_drop", {31'b0, err}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            step(POPO, 0, 0, 8'h00);
            step(RD1, 0, 0, 8'h00);
            #1;
            expv = 8'(8'h20 + 3 * order[7 - k]);
            chk("pop_value", {24'b0, rdata1}, {24'b0, expv});
        end
        step(POPO, 0, 0, 8'h00);
        #1;
        chk("pop_empty_err", {31'b0, err}, 32'h1);
        chk("pop_empty_flag", {31'b0, stk_empty}, 32'h1);
        step(RD1, 0, 0, 8'h00);
        #1;
        chk("pop_empty_r0", {24'b0, rdata1}, 32'h23);

        // mid-sequence reset
        for (int i = 0; i < 3; i++) step(PSH, 3'(i + 2), 0, 8'h00);
        step(RD2, 2, 4, 8'h00);
        @(negedge clk);
        op = NOP;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_count", {28'b0, stk_count}, 32'h0);
        chk("midrst_empty", {31'b0, stk_empty}, 32'h1);
        chk("midrst_r1", {24'b0, rdata1}, 32'h0);
        chk("midrst_r2", {24'b0, rdata2}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(RD1, 3, 0, 8'h00);
        #1;
        chk("post_rst_r3", {24'b0, rdata1}, 32'h0);

        // no bypass from ALU capture into same-cycle read
        step(WR, 7, 0, 8'h42);
        stepx(RD1, 7, 0, 8'h00, 1'b1, 8'h99, 3'b000);
        #1;
        chk("no_bypass", {24'b0, rdata1}, 32'h42);
        step(RD1, 7, 0, 8'h00);
        #1;
        chk("alu_visible", {24'b0, rdata1}, 32'h99);
        step(NOP, 0, 0, 8'h00);
        step(NOP, 0, 0, 8'h00);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_file_stack.md
Name: register_file_stack

Overview:
- Parametrised successor to the CPU's 8-entry register stack.
- Provides a configurable-width/depth general register file with registered dual read ports, register-to-register move/swap, and gated ALU result/flag capture into the top two registers.
- Adds a hardware LIFO call/data stack with push/pop, a stack pointer, and error reporting.
- Sits between the control unit (drives op/ra/rb) and the ALU (result/flags in, operands out).

Parameters:
- DATA_W, 8, register and stack entry width in bits.
- NUM_REGS, 8, number of registers; power of 2, >= 4; AW = log2(NUM_REGS).
- FLAG_W, 3, ALU flag width; must be <= DATA_W; zero-extended into R[NUM_REGS-2].
- STACK_DEPTH, 8, LIFO entries; power of 2, >= 2; SW = log2(STACK_DEPTH)+1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  3  operation code (below), sampled every cycle.
- ra  in  AW  primary register index (dest for write/move/pop, source for read/push).
- rb  in  AW  secondary register index (move source, second read, swap partner).
- wdata  in  DATA_W  write data for WRITE.
- alu_we  in  1  capture ALU result/flags this cycle.
- alu_result  in  DATA_W  ALU result, to R[NUM_REGS-1].
- alu_flags  in  FLAG_W  ALU flags, to R[NUM_REGS-2].
- rdata1  out  DATA_W  read port 1 (registered).
- rdata2  out  DATA_W  read port 2 (registered).
- rd_valid  out  1  one-cycle pulse, rdata valid.
- stk_count  out  SW  occupied stack entries, 0..STACK_DEPTH.
- stk_full  out  1  stk_count == STACK_DEPTH.
- stk_empty  out  1  stk_count == 0.
- err  out  1  one-cycle pulse: push on full or pop on empty.

Behaviour:
- Reset (async, rst=1): all registers, all stack entries, rdata1, rdata2 = 0; rd_valid = 0; err = 0; stk_count = 0; stk_empty = 1; stk_full = 0.
- op encoding (effects visible after the rising edge):
  - 0 NOP: no state change.
  - 1 WRITE: R[ra] <= wdata.
  - 2 READ1: rdata1 <= R[ra]; rdata2 holds.
  - 3 READ2: rdata1 <= R[ra], rdata2 <= R[rb].
  - 4 MOVE: R[ra] <= R[rb]; ra == rb is a no-op.
  - 5 SWAP: R[ra] <= R[rb] and R[rb] <= R[ra] in one cycle; ra == rb is a no-op.
  - 6 PUSH: stack[stk_count] <= R[ra]; stk_count + 1.
  - 7 POP: R[ra] <= stack[stk_count-1]; stk_count - 1.
- Read latency: 1 cycle. rd_valid = 1 exactly in the cycle after READ1/READ2; otherwise 0. rdata1/rdata2 hold their last values when not reading.
- Reads return pre-edge contents. No write-to-read bypass: a READ of a register written by ALU capture in the same cycle returns the old value.
- ALU capture (alu_we=1):
  - R[NUM_REGS-1] <= alu_result.
  - R[NUM_REGS-2] <= {zeros, alu_flags}.
  - No capture when alu_we=0; the registers hold.
- Conflict priority: an op write (WRITE/MOVE/SWAP/POP) to R[NUM_REGS-1] or R[NUM_REGS-2] overrides ALU capture for that register only; the other capture target still updates.
- PUSH when stk_full: stack and count unchanged, err = 1 next cycle.
- POP when stk_empty: R[ra] unchanged, err = 1 next cycle.
- stk_full and stk_empty are combinational decodes of the registered stk_count.
- Stack occupancy wraps nowhere: stk_count saturates at 0 and at STACK_DEPTH via the error rule.
- Stack memory is not cleared on pop; stale entries are never observable.
- All inputs are synchronous to clk. Reset assertion mid-operation aborts it; the first op after rst deasserts executes normally.

Test Plan:
- Reset, then WRITE R2=0xA5, WRITE R3=0x3C, READ2 ra=2 rb=3 -> next cycle rdata1=0xA5, rdata2=0x3C, rd_valid=1 for one cycle only.
- SWAP ra=2 rb=3, then READ2 ra=2 rb=3 -> rdata1=0x3C, rdata2=0xA5; MOVE ra=0 rb=2 then READ1 ra=0 -> rdata1=0x3C.
- alu_we=1, alu_result=0x7F, alu_flags=3'b101 with WRITE R7=0x11 the same cycle -> READ2 ra=6 rb=7 gives rdata1=0x05, rdata2=0x11.
- PUSH R1..R7 plus R0 (8 pushes) -> stk_full=1, stk_count=8; 9th PUSH -> err pulse, stk_count stays 8; 8 POPs into R0 return values in reverse push order; 9th POP -> err pulse, R0 unchanged, stk_empty=1.
- Assert rst mid-sequence with stk_count=3 and nonzero registers -> immediately stk_count=0, stk_empty=1, rdata1=rdata2=0; READ1 of any register afterwards returns 0.
- READ1 ra=7 with alu_we=1 alu_result=0x99 in the same cycle -> rdata1 = old R7; a following READ1 ra=7 -> 0x99.
